// File: rtl/aca_pkg.sv
// Shared constants for the almost-correct adder (ACA) recovery wrapper:
// the FSM state encoding and the default operand/window sizes.
package aca_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SPEC    = 2'd1;
  localparam logic [1:0] CORRECT = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_WINDOW = 6;

endpackage

// File: rtl/aca_spec_window_sum.sv
// Windowed speculative adder: every sum bit sees at most `window` operand bits.
// Also flags any operand pattern whose carry might have been mispredicted.
module aca_spec_window_sum #(
  parameter int width  = 16,
  parameter int window = 6
) (
  input  logic [width-1:0] input1_i,
  input  logic [width-1:0] input2_i,
  output logic [width-1:0] spec_sum_o,
  output logic             spec_carry_o,
  output logic             err_o
);

  logic [width-1:0] p;
  logic [width-1:0] g;
  logic             c;
  logic             cout;
  logic             err;

  assign p = input1_i ^ input2_i;
  assign g = input1_i & input2_i;

  // Each carry restarts from zero at the bottom of its own window.
  always_comb begin
    c          = 1'b0;
    spec_sum_o = '0;
    for (int i = 0; i < width; i++) begin
      c = 1'b0;
      for (int j = 0; j < width; j++) begin
        if ((j >= i - window + 1) && (j < i)) begin
          c = g[j] | (p[j] & c);
        end
      end
      spec_sum_o[i] = p[i] ^ c;
    end
  end

  always_comb begin
    cout = 1'b0;
    for (int j = width - window; j < width; j++) begin
      cout = g[j] | (p[j] & cout);
    end
  end

  assign spec_carry_o = cout;

  // A run of window-1 propagates above bit 0 could carry an unseen carry in.
  always_comb begin
    err = 1'b0;
    for (int k = 1; k <= width - window; k++) begin
      if (&p[k +: window-1]) begin
        err = 1'b1;
      end
    end
  end

  assign err_o = err;

endmodule

// File: rtl/aca_error_recovery_adder.sv
// Variable-latency ACA wrapper: speculative sum in one cycle, exact ripple
// correction in one more when the detector fires, valid/ready on both sides.
module aca_error_recovery_adder
  import aca_pkg::*;
#(
  parameter int width  = DEFAULT_WIDTH,
  parameter int window = DEFAULT_WINDOW
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [width-1:0] input1_i,
  input  logic [width-1:0] input2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [width-1:0] sum_o,
  output logic             carry_o,
  output logic             error_o
);

  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [width-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             error_q, error_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;

  logic [width-1:0] spec_sum;
  logic             spec_carry;
  logic             spec_err;
  logic [width-1:0] exact_sum;
  logic             exact_carry;
  logic             rc;

  aca_spec_window_sum #(
    .width  (width),
    .window (window)
  ) u_spec (
    .input1_i     (a_q),
    .input2_i     (b_q),
    .spec_sum_o   (spec_sum),
    .spec_carry_o (spec_carry),
    .err_o        (spec_err)
  );

  always_comb begin
    rc        = 1'b0;
    exact_sum = '0;
    for (int i = 0; i < width; i++) begin
      exact_sum[i] = a_q[i] ^ b_q[i] ^ rc;
      rc           = (a_q[i] & b_q[i]) | ((a_q[i] ^ b_q[i]) & rc);
    end
    exact_carry = rc;
  end

  // ready is registered, so the first IDLE cycle after reset only raises it.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    error_d = error_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (valid_i && ready_q) begin
          a_d     = input1_i;
          b_d     = input2_i;
          ready_d = 1'b0;
          state_d = SPEC;
        end else begin
          ready_d = 1'b1;
        end
      end
      SPEC: begin
        if (!spec_err) begin
          sum_d   = spec_sum;
          carry_d = spec_carry;
          error_d = 1'b0;
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          state_d = CORRECT;
        end
      end
      CORRECT: begin
        sum_d   = exact_sum;
        carry_d = exact_carry;
        error_d = 1'b1;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      error_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      error_q <= error_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_aca_error_recovery_adder.sv
// Self-checking bench for aca_error_recovery_adder: directed cases, random
// transactions with backpressure, and mid-operation reset.
module tb_aca_error_recovery_adder;

  localparam int WIDTH  = 16;
  localparam int WINDOW = 6;

  logic             clk;
  logic             rst_n;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             error_o;

  int compared;
  int mismatched;

  aca_error_recovery_adder #(
    .width  (WIDTH),
    .window (WINDOW)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .input1_i (input1),
    .input2_i (input2),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .sum_o    (sum_o),
    .carry_o  (carry_o),
    .error_o  (error_o)
  );

  // Free-running clock; edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: would the speculative adder possibly be wrong for this pair?
  function automatic bit modelErr(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned p;
    int unsigned mask;
    p    = int'(a ^ b);
    mask = (32'd1 << (WINDOW - 1)) - 1;
    modelErr = 1'b0;
    for (int k = 1; k <= WIDTH - WINDOW; k++) begin
      if (((p >> k) & mask) == mask) modelErr = 1'b1;
    end
  endfunction

  // Runs one transaction; called and returning at #1 after a rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int stall);
    int unsigned full;
    logic [WIDTH-1:0] expSum;
    logic expCarry;
    logic expErr;
    int expLat;
    int lat;
    int waitCnt;

    full     = int'(a) + int'(b);
    expSum   = full[WIDTH-1:0];
    expCarry = full[WIDTH];
    expErr   = modelErr(a, b);
    expLat   = expErr ? 3 : 2;

    waitCnt = 0;
    while (!ready_o && waitCnt < 10) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("ready_before_accept", 32'(ready_o), 32'd1);

    valid_i = 1'b1;
    input1  = a;
    input2  = b;
    ready_i = (stall == 0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    input1  = WIDTH'($urandom);
    input2  = WIDTH'($urandom);
    checkOutput("ready_drop_after_accept", 32'(ready_o), 32'd0);

    lat = 1;
    while (!valid_o && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("sum", 32'(sum_o), 32'(expSum));
    checkOutput("carry", 32'(carry_o), 32'(expCarry));
    checkOutput("error", 32'(error_o), 32'(expErr));

    for (int s = 0; s < stall; s++) begin
      valid_i = 1'($urandom);
      input1  = WIDTH'($urandom);
      input2  = WIDTH'($urandom);
      @(posedge clk); #1;
      checkOutput("stall_valid", 32'(valid_o), 32'd1);
      checkOutput("stall_ready", 32'(ready_o), 32'd0);
      checkOutput("stall_sum", 32'(sum_o), 32'(expSum));
      checkOutput("stall_carry", 32'(carry_o), 32'(expCarry));
      checkOutput("stall_error", 32'(error_o), 32'(expErr));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;

    @(posedge clk); #1;
    checkOutput("valid_one_cycle", 32'(valid_o), 32'd0);
    checkOutput("ready_back_in_idle", 32'(ready_o), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    valid_i    = 1'b0;
    ready_i    = 1'b1;
    input1     = '0;
    input2     = '0;

    #12;
    checkOutput("rst_ready", 32'(ready_o), 32'd0);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_sum", 32'(sum_o), 32'd0);
    checkOutput("rst_carry", 32'(carry_o), 32'd0);
    checkOutput("rst_error", 32'(error_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_first_edge", 32'(ready_o), 32'd1);

    applyStimulus(16'h0003, 16'h0005, 0);
    applyStimulus(16'h00FF, 16'h0001, 0);
    applyStimulus(16'hFFFF, 16'h0001, 0);
    applyStimulus(16'h003E, 16'h0000, 0);
    applyStimulus(16'h1234, 16'h4321, 4);
    applyStimulus(16'h00FF, 16'hFF01, 4);

    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = (n % 3 == 0) ? (~ra ^ WIDTH'($urandom_range(0, 15))) : WIDTH'($urandom);
      applyStimulus(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Reset while the correction cycle is in progress.
    valid_i = 1'b1;
    input1  = 16'h00FF;
    input2  = 16'h0001;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(valid_o), 32'd0);
    checkOutput("midrst_ready", 32'(ready_o), 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_ready_before_edge", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("midrst_ready_after_edge", 32'(ready_o), 32'd1);
    for (int n = 0; n < 4; n++) begin
      checkOutput("midrst_no_stale_valid", 32'(valid_o), 32'd0);
      @(posedge clk); #1;
    end
    applyStimulus(16'h0003, 16'h0005, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
